// File: rtl/mem_app_pkg.sv
// Shared definitions for the memory application blocks: default geometry, scan FSM states and
// the one-hot value decode that mirrors the writer's entry encoder.
package mem_app_pkg;

    localparam int AW_DEF   = 3;
    localparam int DW_DEF   = 4;
    localparam int ONEHOT_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_CONV,
        S_DONE
    } state_t;

    // Values 1..9 map to bit (value-1); 0 and anything above 9 have no entry and decode to zero.
    function automatic logic [ONEHOT_W-1:0] onehot_decode(input int unsigned value);
        logic [ONEHOT_W-1:0] r;
        r = '0;
        if (value >= 1 && value <= ONEHOT_W) begin
            r = ONEHOT_W'(1) << (value - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, BIN_W steps per conversion.
// The bcd output only changes on the cycle done pulses.
module bin_to_bcd_seq #(
    parameter int BIN_W = 7,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]       shreg_p0;
    logic [BCD_W-1:0]       acc_p0;
    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+BIN_W-1:0] joined;
    logic [CNT_W-1:0]       cnt;
    logic                   active;

    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < NDIG; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign acc_adj = add3_digits(acc_p0);
    assign joined  = {acc_adj, shreg_p0} << 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= CNT_W'(BIN_W);
            end else if (active) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Datapath: shift register and BCD accumulator carry no reset; start reloads them.
    always_ff @(posedge clk) begin
        if (start) begin
            shreg_p0 <= bin;
            acc_p0   <= '0;
        end else if (active) begin
            shreg_p0 <= joined[BIN_W-1:0];
            acc_p0   <= joined[BCD_W+BIN_W-1 -: BCD_W];
            if (cnt == CNT_W'(1)) begin
                bcd <= joined[BCD_W+BIN_W-1 -: BCD_W];
            end
        end
    end

endmodule

// File: rtl/mem_scan_reader.sv
// Sweeps a range of memory words, streams each out (raw and one-hot) over valid/ready, and
// totals them in binary and BCD. Build option SCAN_WRAP_EN: wrap the address instead of stopping at the top.
module mem_scan_reader
    import mem_app_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int SUM_W = 7,
    parameter int NDIG  = 3
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                START,
    input  logic [AW-1:0]       START_ADDR,
    input  logic [AW:0]         COUNT,
    output logic                RD_EN,
    output logic [AW-1:0]       RD_ADDR,
    input  logic [DW-1:0]       RD_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [DW-1:0]       OUT_DATA,
    output logic [ONEHOT_W-1:0] OUT_ONEHOT,
    output logic                BUSY,
    output logic                DONE,
    output logic [SUM_W-1:0]    SUM,
    output logic [4*NDIG-1:0]   SUM_BCD
);

    localparam int REM_W = AW + 1;

    state_t                 state;
    logic [AW-1:0]          addr;
    logic [REM_W-1:0]       remaining;
    logic                   last_word;
    logic                   conv_start;
    logic                   conv_done;
    logic [4*NDIG-1:0]      conv_bcd;

`ifdef SCAN_WRAP_EN
    assign last_word = (remaining == REM_W'(1));
`else
    localparam logic [AW-1:0] TOP_ADDR = '1;
    // The top address ends the sweep even if words remain; the partial total is still converted.
    assign last_word = (remaining == REM_W'(1)) || (addr == TOP_ADDR);
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            addr       <= '0;
            remaining  <= '0;
            RD_EN      <= 1'b0;
            RD_ADDR    <= '0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_ONEHOT <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            SUM        <= '0;
            SUM_BCD    <= '0;
            conv_start <= 1'b0;
        end else begin
            RD_EN      <= 1'b0;
            DONE       <= 1'b0;
            conv_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The cycle carrying the DONE pulse still counts as the done phase.
                    if (START && !DONE) begin
                        addr      <= START_ADDR;
                        remaining <= COUNT;
                        SUM       <= '0;
                        SUM_BCD   <= '0;
                        BUSY      <= 1'b1;
                        if (COUNT == '0) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_REQ;
                            RD_EN   <= 1'b1;
                            RD_ADDR <= START_ADDR;
                        end
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    OUT_DATA   <= RD_DATA;
                    OUT_ONEHOT <= onehot_decode(32'(RD_DATA));
                    OUT_VALID  <= 1'b1;
                    state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        SUM       <= SUM + SUM_W'(OUT_DATA);
                        addr      <= addr + AW'(1);
                        remaining <= remaining - REM_W'(1);
                        if (last_word) begin
                            state      <= S_CONV;
                            conv_start <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            RD_EN   <= 1'b1;
                            RD_ADDR <= addr + AW'(1);
                        end
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        SUM_BCD <= conv_bcd;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    bin_to_bcd_seq #(
        .BIN_W (SUM_W),
        .NDIG  (NDIG)
    ) u_bcd (
        .clk   (CLK),
        .rst_n (RSTn),
        .start (conv_start),
        .bin   (SUM),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader: a behavioural scan model (expected address/word queues and
// totals) checked every cycle, plus literal expectations per scenario.
module tb_mem_scan_reader;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int SUM_W = 7;
    localparam int NDIG  = 3;
    localparam int DEPTH = 1 << AW;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              START = 1'b0;
    logic [AW-1:0]     START_ADDR = '0;
    logic [AW:0]       COUNT = '0;
    logic              RD_EN;
    logic [AW-1:0]     RD_ADDR;
    logic [DW-1:0]     RD_DATA = '0;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b1;
    logic [DW-1:0]     OUT_DATA;
    logic [8:0]        OUT_ONEHOT;
    logic              BUSY;
    logic              DONE;
    logic [SUM_W-1:0]  SUM;
    logic [4*NDIG-1:0] SUM_BCD;

    mem_scan_reader #(.AW(AW), .DW(DW), .SUM_W(SUM_W), .NDIG(NDIG)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .START_ADDR(START_ADDR), .COUNT(COUNT),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_ONEHOT(OUT_ONEHOT),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .SUM_BCD(SUM_BCD)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) if (RD_EN) RD_DATA <= mem[RD_ADDR];

    int tests = 0;
    int fails = 0;

    int q_addr[$];
    int q_word[$];
    int model_sum = 0;
    int exp_sum = 0;
    int exp_bcd = 0;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    int done_cnt = 0;
    int words_seen = 0;
    int seen_data[16];
    int seen_oh[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_onehot(input int v);
        return (v >= 1 && v <= 9) ? (1 << (v - 1)) : 0;
    endfunction

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Expected read order and totals straight from the sweep rules.
    task automatic plan(input int sa, input int cnt);
        int a;
        q_addr.delete();
        q_word.delete();
        exp_sum    = 0;
        model_sum  = 0;
        words_seen = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            a = sa + i;
`ifdef SCAN_WRAP_EN
            a = a % DEPTH;
`else
            if (a >= DEPTH) break;
`endif
            q_addr.push_back(a);
            q_word.push_back(int'(mem[a]));
            exp_sum += int'(mem[a]);
        end
        exp_bcd = to_bcd(exp_sum);
    endtask

    always @(negedge CLK) begin
        if (mon_en && RSTn) begin
            if (BUSY || DONE) check("sum_running", SUM, model_sum);
            if (RD_EN) begin
                check("rd_expected", q_addr.size() != 0, 1);
                if (q_addr.size() != 0) check("rd_addr", RD_ADDR, q_addr.pop_front());
            end
            if (prev_stall) check("valid_held", OUT_VALID, 1);
            if (OUT_VALID) begin
                check("word_expected", q_word.size() != 0, 1);
                if (q_word.size() != 0) begin
                    check("out_data", OUT_DATA, q_word[0]);
                    check("out_onehot", OUT_ONEHOT, ref_onehot(q_word[0]));
                    if (OUT_READY) begin
                        if (words_seen < 16) begin
                            seen_data[words_seen] = int'(OUT_DATA);
                            seen_oh[words_seen]   = int'(OUT_ONEHOT);
                        end
                        model_sum += q_word.pop_front();
                        words_seen++;
                    end
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            if (DONE) begin
                done_cnt++;
                check("done_bcd", SUM_BCD, exp_bcd);
                check("done_busy", BUSY, 0);
                check("done_words_left", q_word.size(), 0);
                check("done_sum_model", SUM, exp_sum);
            end
        end
    end

    task automatic run_scan(input int sa, input int cnt, input int lit_sum, input int lit_bcd,
                            input int lit_words, input int stall_word, input int poke_at);
        int n;
        int stall_left;
        bit got_done;
        plan(sa, cnt);
        mon_en = 1'b1;
        stall_left = 5;
        got_done = 1'b0;
        @(posedge CLK); #1;
        START_ADDR = AW'(sa);
        COUNT      = (AW+1)'(cnt);
        START      = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (!got_done && n < 400) begin
            @(posedge CLK); #1;
            n++;
            if (DONE) got_done = 1'b1;
            if (n == poke_at) begin
                START = 1'b1; START_ADDR = 3'd5; COUNT = 4'd1;
            end else begin
                START = 1'b0;
            end
            if (stall_word >= 0 && OUT_VALID && words_seen == stall_word && stall_left > 0) begin
                OUT_READY = 1'b0;
                stall_left--;
                check("stall_data", OUT_DATA, mem[(sa + stall_word) % DEPTH]);
            end else begin
                OUT_READY = 1'b1;
            end
        end
        check("done_in_time", got_done, 1);
        START = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("lit_sum", SUM, lit_sum);
        check("lit_bcd", SUM_BCD, lit_bcd);
        check("lit_words", words_seen, lit_words);
        check("single_done", done_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        int n;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rd_en", RD_EN, 0);
        check("rst_rd_addr", RD_ADDR, 0);
        check("rst_valid", OUT_VALID, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_onehot", OUT_ONEHOT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_sum", SUM, 0);
        check("rst_bcd", SUM_BCD, 0);
        RSTn = 1'b1;

        // 1: ascending words, full sweep
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        run_scan(0, 8, 36, 12'h036, 8, -1, -1);
        check("t1_first_oh", seen_oh[0], 9'h001);
        check("t1_last_oh", seen_oh[7], 9'h080);
        check("t1_last_data", seen_data[7], 8);

        // 2: consumer stalls on word 3
        run_scan(0, 8, 36, 12'h036, 8, 2, -1);
        check("t2_word3", seen_data[2], 3);

        // 3: sweep crossing the top address
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[6] = 4'd9; mem[7] = 4'd9; mem[0] = 4'd9; mem[1] = 4'd9;
`ifdef SCAN_WRAP_EN
        run_scan(6, 4, 36, 12'h036, 4, -1, -1);
`else
        run_scan(6, 4, 18, 12'h018, 2, -1, -1);
`endif

        // 4: words without a one-hot entry, then an empty scan
        mem[0] = 4'd0; mem[1] = 4'd12; mem[2] = 4'd9;
        run_scan(0, 3, 21, 12'h021, 3, -1, -1);
        check("t4_oh_zero", seen_oh[0], 0);
        check("t4_oh_twelve", seen_oh[1], 0);
        check("t4_oh_nine", seen_oh[2], 9'h100);
        plan(0, 0);
        @(posedge CLK); #1;
        START_ADDR = '0; COUNT = '0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("t4_c0_busy", BUSY, 1);
        check("t4_c0_early_done", DONE, 0);
        @(posedge CLK); #1;
        check("t4_c0_done", DONE, 1);
        check("t4_c0_busy_low", BUSY, 0);
        check("t4_c0_sum", SUM, 0);
        check("t4_c0_bcd", SUM_BCD, 0);
        repeat (3) @(posedge CLK);

        // 5: maximum total with an ignored START mid-scan
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'd15;
        run_scan(0, 8, 120, 12'h120, 8, -1, 6);

        // 6: reset while a word waits in EMIT
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        plan(0, 8);
        OUT_READY = 1'b0;
        @(posedge CLK); #1;
        START_ADDR = '0; COUNT = 4'd8; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("t6_reached_emit", OUT_VALID, 1);
        mon_en = 1'b0;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        check("t6_rd_en", RD_EN, 0);
        check("t6_valid", OUT_VALID, 0);
        check("t6_data", OUT_DATA, 0);
        check("t6_onehot", OUT_ONEHOT, 0);
        check("t6_busy", BUSY, 0);
        check("t6_done", DONE, 0);
        check("t6_sum", SUM, 0);
        check("t6_bcd", SUM_BCD, 0);
        OUT_READY = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("t6_no_done", saw_done, 0);
        run_scan(0, 8, 36, 12'h036, 8, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
